// File: rtl/rom_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memory.
// slave = arbiter view, master = masters/memory (testbench) view.
interface rom_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [DATA_W-1:0] m0_rdata_o;
  logic              hold_o;
  logic              m1_req_i;
  logic              m1_lock_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [DATA_W-1:0] m1_rdata_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  m0_req_i, m0_addr_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, hold_o,
    input  m1_req_i, m1_lock_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output m0_req_i, m0_addr_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, hold_o,
    output m1_req_i, m1_lock_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/rom_bus_arbiter.sv
// Two-master arbiter for the single-port instruction memory.
// M1 (loader) has priority; M0 (fetch) gets a starvation guard.
module rom_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  rom_bus_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

  // owner: 1 = M1 holds the bus, 0 = M0
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_mst_q, rd_mst_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic lock_win;
  logic starve_win;
  logic m0_gnt;
  logic m1_gnt;
  logic m0_rvalid;
  logic m1_rvalid;

  // Fixed-priority grant: lock, starvation, M1, M0; nothing in reset
  always_comb begin
    lock_win   = owner_q & bus.m1_lock_i & bus.m1_req_i;
    starve_win = (starve_cnt_q == SMAX) & bus.m0_req_i;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    if (!rst) begin
      if (lock_win)
        m1_gnt = 1'b1;
      else if (starve_win)
        m0_gnt = 1'b1;
      else if (bus.m1_req_i)
        m1_gnt = 1'b1;
      else if (bus.m0_req_i)
        m0_gnt = 1'b1;
    end
  end

  // Next state for owner, starvation counter, read tag and held rdata
  always_comb begin
    owner_d = owner_q;
    if (m1_gnt)
      owner_d = 1'b1;
    else if (m0_gnt)
      owner_d = 1'b0;

    starve_cnt_d = '0;
    if (bus.m0_req_i && !m0_gnt)
      starve_cnt_d = (starve_cnt_q == SMAX) ? SMAX
                                            : starve_cnt_q + 1'b1;

    rd_vld_d = m0_gnt | (m1_gnt & ~bus.m1_we_i);
    rd_mst_d = m1_gnt;

    m0_rvalid = rd_vld_q & ~rd_mst_q;
    m1_rvalid = rd_vld_q & rd_mst_q;

    m0_rdata_d = m0_rvalid ? bus.mem_rdata_i : m0_rdata_q;
    m1_rdata_d = m1_rvalid ? bus.mem_rdata_i : m1_rdata_q;
  end

  // State registers; reset drops any read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
      rd_vld_q     <= 1'b0;
      rd_mst_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_mst_q     <= rd_mst_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Master-side outputs
  always_comb begin
    bus.m0_gnt_o    = m0_gnt;
    bus.m1_gnt_o    = m1_gnt;
    bus.hold_o      = bus.m0_req_i & ~m0_gnt;
    bus.m0_rvalid_o = m0_rvalid;
    bus.m1_rvalid_o = m1_rvalid;
    bus.m0_rdata_o  = m0_rvalid ? bus.mem_rdata_i : m0_rdata_q;
    bus.m1_rdata_o  = m1_rvalid ? bus.mem_rdata_i : m1_rdata_q;
  end

  // Memory-side mux from the granted master, zero when idle
  always_comb begin
    bus.mem_en_o    = m0_gnt | m1_gnt;
    bus.mem_we_o    = m1_gnt & bus.m1_we_i;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (m1_gnt) begin
      bus.mem_addr_o  = bus.m1_addr_i;
      bus.mem_wdata_o = bus.m1_wdata_i;
    end else if (m0_gnt) begin
      bus.mem_addr_o  = bus.m0_addr_i;
    end
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter.
// Memory lives here; expectations come from a priority-list model.
module tb_rom_bus_arbiter;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  rom_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  // Memory: synchronous write, 1-cycle read
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o)
        mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
      else
        bus.mem_rdata_i <= mem[bus.mem_addr_o[9:2]];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  int          starve;
  bit          owner;
  bit          pend_v, pend_m;
  logic [31:0] pend_d, last0, last1;
  bit          e0, e1, ev0, ev1;
  logic [31:0] ed0, ed1, eaddr;

  function automatic void model_reset();
    starve = 0; owner = 1'b0;
    pend_v = 1'b0; pend_m = 1'b0; pend_d = '0;
    last0 = '0; last1 = '0;
  endfunction

  function automatic void model_eval();
    e0 = 1'b0; e1 = 1'b0;
    if (owner && bus.m1_lock_i && bus.m1_req_i) e1 = 1'b1;
    else if (starve == SMAX && bus.m0_req_i)    e0 = 1'b1;
    else if (bus.m1_req_i)                      e1 = 1'b1;
    else if (bus.m0_req_i)                      e0 = 1'b1;
    ev0 = pend_v && !pend_m;
    ev1 = pend_v && pend_m;
    ed0 = ev0 ? pend_d : last0;
    ed1 = ev1 ? pend_d : last1;
    eaddr = e1 ? bus.m1_addr_i : (e0 ? bus.m0_addr_i : 32'h0);
  endfunction

  function automatic void model_advance();
    last0 = ed0; last1 = ed1;
    if (bus.m0_req_i && !e0) starve = (starve < SMAX) ? starve + 1 : SMAX;
    else starve = 0;
    if (e1) owner = 1'b1;
    else if (e0) owner = 1'b0;
    pend_v = 1'b0; pend_m = e1;
    if (e0) begin
      pend_v = 1'b1; pend_d = ref_mem[bus.m0_addr_i[9:2]];
    end else if (e1 && bus.m1_we_i) begin
      ref_mem[bus.m1_addr_i[9:2]] = bus.m1_wdata_i;
    end else if (e1) begin
      pend_v = 1'b1; pend_d = ref_mem[bus.m1_addr_i[9:2]];
    end
  endfunction

  task automatic drive(input bit r0, input logic [31:0] a0,
                       input bit r1, input bit lk, input bit we,
                       input logic [31:0] a1, input logic [31:0] wd);
    bus.m0_req_i = r0; bus.m0_addr_i = a0;
    bus.m1_req_i = r1; bus.m1_lock_i = lk; bus.m1_we_i = we;
    bus.m1_addr_i = a1; bus.m1_wdata_i = wd;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic adv();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 32'h4, 1, 0, 0, 32'h8, 0);
    settle();
    n_cmp++; if (bus.m0_gnt_o !== 1'b0 || bus.m1_gnt_o !== 1'b0) begin
      n_err++; $display("FAIL reset_gnt got %b%b want 00", bus.m0_gnt_o, bus.m1_gnt_o); end
    n_cmp++; if (bus.mem_en_o !== 1'b0) begin
      n_err++; $display("FAIL reset_mem_en got %b want 0", bus.mem_en_o); end
    n_cmp++; if ({bus.m0_rvalid_o, bus.m1_rvalid_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_rvalid got %b%b want 00", bus.m0_rvalid_o, bus.m1_rvalid_o); end
    n_cmp++; if (bus.m0_rdata_o !== 32'h0 || bus.m1_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata got %h/%h want 0", bus.m0_rdata_o, bus.m1_rdata_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    settle(); adv();
  endtask

  task automatic test_t1();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 32'(i * 4), 0, 0, 0, 0, 0);
      settle();
      n_cmp++; if (bus.m0_gnt_o !== (i < 3) || bus.hold_o !== 1'b0) begin
        n_err++; $display("FAIL t1_gnt[%0d] got g=%b h=%b want g=%b h=0", i, bus.m0_gnt_o, bus.hold_o, i < 3); end
      n_cmp++; if (bus.m0_rvalid_o !== (i > 0) || (i > 0 && bus.m0_rdata_o !== ref_mem[i-1])) begin
        n_err++; $display("FAIL t1_rdata[%0d] got v=%b d=%h want v=%b d=%h", i, bus.m0_rvalid_o, bus.m0_rdata_o, i > 0, ref_mem[(i > 0) ? i-1 : 0]); end
      adv();
    end
  endtask

  task automatic test_t2();
    drive(0, 0, 1, 0, 1, 32'h10, 32'h13);
    settle();
    n_cmp++; if (bus.m1_gnt_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h10) begin
      n_err++; $display("FAIL t2_write got g=%b we=%b a=%h want 1 1 10", bus.m1_gnt_o, bus.mem_we_o, bus.mem_addr_o); end
    adv();
    drive(0, 0, 1, 0, 0, 32'h10, 0);
    settle();
    n_cmp++; if (bus.m1_rvalid_o !== 1'b0 || bus.mem_we_o !== 1'b0 || bus.m1_gnt_o !== 1'b1) begin
      n_err++; $display("FAIL t2_read_issue got v=%b we=%b g=%b want 0 0 1", bus.m1_rvalid_o, bus.mem_we_o, bus.m1_gnt_o); end
    adv();
    drive(0, 0, 0, 0, 0, 0, 0);
    settle();
    n_cmp++; if (bus.m1_rvalid_o !== 1'b1 || bus.m1_rdata_o !== 32'h13) begin
      n_err++; $display("FAIL t2_read_back got v=%b d=%h want 1 00000013", bus.m1_rvalid_o, bus.m1_rdata_o); end
    adv();
    settle();
    n_cmp++; if (bus.m1_rvalid_o !== 1'b0 || bus.m1_rdata_o !== 32'h13) begin
      n_err++; $display("FAIL t2_hold got v=%b d=%h want 0 00000013", bus.m1_rvalid_o, bus.m1_rdata_o); end
    adv();
  endtask

  task automatic test_t3();
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h20, 1, 0, 0, 32'h40, 0);
      settle();
      n_cmp++; if (bus.m0_gnt_o !== (k % 5 == 4) || bus.m1_gnt_o !== (k % 5 != 4) || bus.hold_o !== (k % 5 != 4)) begin
        n_err++; $display("FAIL t3_starve[%0d] got m0=%b m1=%b h=%b want m0=%b", k, bus.m0_gnt_o, bus.m1_gnt_o, bus.hold_o, k % 5 == 4); end
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    settle(); adv();
  endtask

  task automatic test_t4();
    for (int k = 0; k < 11; k++) begin
      drive(1, 32'h24, 1, k < 10, 0, 32'h44, 0);
      settle();
      n_cmp++; if (bus.m1_gnt_o !== (k < 10) || bus.m0_gnt_o !== (k == 10)) begin
        n_err++; $display("FAIL t4_lock[%0d] got m0=%b m1=%b want m0=%b", k, bus.m0_gnt_o, bus.m1_gnt_o, k == 10); end
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    settle(); adv();
  endtask

  task automatic test_t5();
    drive(1, 32'h8, 0, 0, 0, 0, 0);
    settle(); adv();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.m0_rvalid_o !== 1'b0 || bus.m0_gnt_o !== 1'b0 || bus.mem_en_o !== 1'b0 || bus.m0_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL t5_rst got v=%b g=%b en=%b d=%h want 0 0 0 0", bus.m0_rvalid_o, bus.m0_gnt_o, bus.mem_en_o, bus.m0_rdata_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, 32'(i * 4), 0, 0, 0, 0, 0);
      settle();
      n_cmp++; if (bus.m0_gnt_o !== (i < 2) || bus.m0_rvalid_o !== (i > 0) || (i > 0 && bus.m0_rdata_o !== ref_mem[i-1])) begin
        n_err++; $display("FAIL t5_after[%0d] got g=%b v=%b d=%h", i, bus.m0_gnt_o, bus.m0_rvalid_o, bus.m0_rdata_o); end
      adv();
    end
  endtask

  task automatic test_t6();
    drive(0, 0, 1, 0, 0, 32'h30, 0);
    settle(); adv();
    drive(1, 32'h34, 0, 0, 0, 32'h30, 0);
    settle();
    n_cmp++; if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0 || bus.mem_addr_o !== 32'h34) begin
      n_err++; $display("FAIL t6_handover got m0=%b m1=%b a=%h want 1 0 34", bus.m0_gnt_o, bus.m1_gnt_o, bus.mem_addr_o); end
    adv();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, {22'h0, 8'($urandom), 2'b00},
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, {22'h0, 8'($urandom), 2'b00},
            $urandom);
      settle();
      n_cmp++; if ({bus.m0_gnt_o, bus.m1_gnt_o, bus.hold_o} !== {e0, e1, bus.m0_req_i & ~e0}) begin
        n_err++; $display("FAIL rnd_gnt[%0d] got %b%b%b want %b%b%b", k, bus.m0_gnt_o, bus.m1_gnt_o, bus.hold_o, e0, e1, bus.m0_req_i & ~e0); end
      n_cmp++; if ({bus.mem_en_o, bus.mem_we_o} !== {e0 | e1, e1 & bus.m1_we_i} || bus.mem_addr_o !== eaddr) begin
        n_err++; $display("FAIL rnd_mem[%0d] got en=%b we=%b a=%h want a=%h", k, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, eaddr); end
      n_cmp++; if ({bus.m0_rvalid_o, bus.m1_rvalid_o} !== {ev0, ev1}) begin
        n_err++; $display("FAIL rnd_rvalid[%0d] got %b%b want %b%b", k, bus.m0_rvalid_o, bus.m1_rvalid_o, ev0, ev1); end
      n_cmp++; if (bus.m0_rdata_o !== ed0 || bus.m1_rdata_o !== ed1) begin
        n_err++; $display("FAIL rnd_rdata[%0d] got %h/%h want %h/%h", k, bus.m0_rdata_o, bus.m1_rdata_o, ed0, ed1); end
      adv();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_t1();
    test_t2();
    test_t3();
    test_t4();
    test_t5();
    test_t6();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
